// File: rtl/alu_operand_stage_if.sv
// Valid/ready buses around the ID/EX operand stage: decode -> stage and stage -> ALU.
// master = the operand stage itself; slave = the surrounding pipeline (decode + ALU).
interface alu_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  // decode -> stage
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_imm;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;

  // stage -> ALU
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0][7:0]       ALUc;
  logic [XLEN-1:0]       aluSrcA;
  logic [XLEN-1:0]       aluSrcB;
  logic [XLEN-1:0]       out_rs2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_pc;

  modport master (
    input  in_valid, in_instr, in_pc, in_imm, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, ALUc, aluSrcA, aluSrcB, out_rs2, out_rd, out_pc
  );

  modport slave (
    output in_valid, in_instr, in_pc, in_imm, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, ALUc, aluSrcA, aluSrcB, out_rs2, out_rd, out_pc
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID->EX register feeding the RV32I ALU: operand select, ALUc control bytes, load-use stall, flush.
// Build option: define ALU_OPERAND_FWD_EN to enable EX/MEM + MEM/WB forwarding and the load-use stall.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  alu_operand_stage_if.master   bus,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wen,
  input  logic                  mem_is_load,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wen,
  input  logic [XLEN-1:0]       wb_result
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  typedef struct packed {
    logic            known;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            force_add;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      shamt;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
  } dec_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1_idx;
  logic [REG_ADDR_W-1:0] rs2_idx;
  logic [REG_ADDR_W-1:0] rd_idx;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic                  hazard;
  logic                  transfer;
  dec_t                  dec;

  assign opcode  = bus.in_instr[6:0];
  assign rd_idx  = bus.in_instr[11:7];
  assign funct3  = bus.in_instr[14:12];
  assign rs1_idx = bus.in_instr[19:15];
  assign rs2_idx = bus.in_instr[24:20];

`ifdef ALU_OPERAND_FWD_EN
  // x0 never forwards; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    rs1_val = bus.rs1_data;
    if (rs1_idx != '0) begin
      if (mem_wen && (mem_rd == rs1_idx))     rs1_val = mem_result;
      else if (wb_wen && (wb_rd == rs1_idx))  rs1_val = wb_result;
    end
  end

  always_comb begin
    rs2_val = bus.rs2_data;
    if (rs2_idx != '0) begin
      if (mem_wen && (mem_rd == rs2_idx))     rs2_val = mem_result;
      else if (wb_wen && (wb_rd == rs2_idx))  rs2_val = wb_result;
    end
  end

  assign hazard = mem_is_load && mem_wen && (mem_rd != '0) &&
                  ((dec.uses_rs1 && (mem_rd == rs1_idx)) ||
                   (dec.uses_rs2 && (mem_rd == rs2_idx)));
`else
  assign rs1_val = bus.rs1_data;
  assign rs2_val = bus.rs2_data;
  assign hazard  = 1'b0;

  // Bypass inputs stay on the port list so both builds share one pinout.
  logic unused_fwd;
  assign unused_fwd = ^{mem_rd, mem_wen, mem_is_load, mem_result, wb_rd, wb_wen,
                        wb_result, rs1_idx, rs2_idx, dec.uses_rs1, dec.uses_rs2};
`endif

  // NOTE: every field gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.funct3    = funct3;
        dec.funct7    = bus.in_instr[31:25];
        dec.shamt     = rs2_val[4:0];
        dec.src_a     = rs1_val;
        dec.src_b     = rs2_val;
      end
      OPC_OP_IMM: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.funct3    = funct3;
        dec.funct7    = (funct3 == 3'b101) ? bus.in_instr[31:25] : 7'd0;
        dec.shamt     = bus.in_instr[24:20];
        dec.src_a     = rs1_val;
        dec.src_b     = bus.in_imm;
      end
      OPC_LOAD: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.force_add = 1'b1;
        dec.src_a     = rs1_val;
        dec.src_b     = bus.in_imm;
      end
      OPC_STORE: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.force_add = 1'b1;
        dec.src_a     = rs1_val;
        dec.src_b     = bus.in_imm;
      end
      OPC_BRANCH: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.funct3    = funct3;
        dec.src_a     = rs1_val;
        dec.src_b     = rs2_val;
      end
      OPC_LUI: begin
        dec.known     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.force_add = 1'b1;
        dec.src_b     = bus.in_imm;
      end
      OPC_AUIPC: begin
        dec.known     = 1'b1;
        dec.writes_rd = 1'b1;
        dec.force_add = 1'b1;
        dec.src_a     = bus.in_pc;
        dec.src_b     = bus.in_imm;
      end
      // Link address pc+4 is the ALU result; jump targets are formed elsewhere.
      OPC_JAL, OPC_JALR: begin
        dec.known     = 1'b1;
        dec.uses_rs1  = (opcode == OPC_JALR);
        dec.writes_rd = 1'b1;
        dec.force_add = 1'b1;
        dec.src_a     = bus.in_pc;
        dec.src_b     = XLEN'(4);
      end
      default: ;
    endcase
  end

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign transfer     = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: reset is asynchronous and clears the whole payload, not just out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.ALUc      <= '0;
      bus.aluSrcA   <= '0;
      bus.aluSrcB   <= '0;
      bus.out_rs2   <= '0;
      bus.out_rd    <= '0;
      bus.out_pc    <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (transfer) begin
      // Unknown opcodes are consumed but surface as a bubble.
      bus.out_valid <= dec.known;
      bus.ALUc      <= {{1'b0, opcode},
                        {3'b000, dec.shamt},
                        {1'b0, dec.funct7},
                        {dec.force_add, 4'b0000, dec.funct3}};
      bus.aluSrcA   <= dec.src_a;
      bus.aluSrcB   <= dec.src_b;
      bus.out_rs2   <= rs2_val;
      bus.out_rd    <= dec.writes_rd ? rd_idx : '0;
      bus.out_pc    <= bus.in_pc;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed, table-driven bench for alu_operand_stage; covers both the default and forwarding builds.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp_valid;
    logic        chk_payload;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_rs2;
    logic [4:0]  exp_rd;
    logic [31:0] exp_aluc;
    logic [31:0] aluc_mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [4:0]  mem_rd;
  logic        mem_wen;
  logic        mem_is_load;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_result;

  int checks = 0;
  int errors = 0;

  alu_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .mem_rd      (mem_rd),
    .mem_wen     (mem_wen),
    .mem_is_load (mem_is_load),
    .mem_result  (mem_result),
    .wb_rd       (wb_rd),
    .wb_wen      (wb_wen),
    .wb_result   (wb_result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, pc, imm, rs1, rs2);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_imm   = imm;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mw, ml, input logic [31:0] mres,
                         input logic [4:0] wrd, input logic ww, input logic [31:0] wres);
    mem_rd      = mrd;
    mem_wen     = mw;
    mem_is_load = ml;
    mem_result  = mres;
    wb_rd       = wrd;
    wb_wen      = ww;
    wb_result   = wres;
  endtask

  task automatic add_vec(inout vec_t q[$], input string nm, input logic [31:0] instr, pc, imm, rs1, rs2,
                         input logic ev, cp, input logic [31:0] ea, eb, ers2,
                         input logic [4:0] erd, input logic [31:0] ealuc, amask);
    vec_t v;
    v.name = nm;  v.instr = instr; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.exp_valid = ev; v.chk_payload = cp; v.exp_a = ea; v.exp_b = eb; v.exp_rs2 = ers2;
    v.exp_rd = erd; v.exp_aluc = ealuc; v.aluc_mask = amask;
    q.push_back(v);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] add_x3_x1_x2;
    logic [31:0] sub_x6_x1_x2;
    logic [31:0] lui_x9;

    add_x3_x1_x2 = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    sub_x6_x1_x2 = {7'h20, 5'd2, 5'd1, 3'b000, 5'd6, 7'h33};
    lui_x9       = {20'h00040, 5'd9, 7'h37};

    //            name     instr                                       pc       imm           rs1           rs2           v  p  A             B             rs2           rd     ALUc          mask
    add_vec(vecs, "add",   add_x3_x1_x2,                               32'h40,  32'h0,        32'd5,        32'd7,        1, 1, 32'd5,        32'd7,        32'd7,        5'd3,  32'h33070000, 32'hffffffff);
    add_vec(vecs, "sub",   {7'h20, 5'd5, 5'd4, 3'b000, 5'd6, 7'h33},   32'h44,  32'h0,        32'd20,       32'h123,      1, 1, 32'd20,       32'h123,      32'h123,      5'd6,  32'h33032000, 32'hffffffff);
    add_vec(vecs, "srai",  {7'h20, 5'd5, 5'd1, 3'b101, 5'd7, 7'h13},   32'h48,  32'h405,      32'h80000000, 32'h11,       1, 1, 32'h80000000, 32'h405,      32'h11,       5'd7,  32'h13052005, 32'hffffffff);
    add_vec(vecs, "addi",  {12'hfff, 5'd1, 3'b000, 5'd8, 7'h13},       32'h4c,  32'hffffffff, 32'd10,       32'h22,       1, 1, 32'd10,       32'hffffffff, 32'h22,       5'd8,  32'h131f0000, 32'hffffffff);
    add_vec(vecs, "lw",    {12'd12, 5'd1, 3'b010, 5'd4, 7'h03},        32'h50,  32'd12,       32'h1000,     32'h33,       1, 1, 32'h1000,     32'd12,       32'h33,       5'd4,  32'h03000080, 32'hff00ffff);
    add_vec(vecs, "sw",    {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'h23},    32'h54,  32'd8,        32'h2000,     32'hdeadbeef, 1, 1, 32'h2000,     32'd8,        32'hdeadbeef, 5'd0,  32'h23000080, 32'hff00ffff);
    add_vec(vecs, "bne",   {7'd0, 5'd2, 5'd1, 3'b001, 5'b01000, 7'h63},32'h58,  32'd8,        32'd3,        32'd4,        1, 1, 32'd3,        32'd4,        32'd4,        5'd0,  32'h63000001, 32'hff00ffff);
    add_vec(vecs, "lui",   lui_x9,                                     32'h5c,  32'h40000,    32'h55,       32'h66,       1, 1, 32'd0,        32'h40000,    32'h66,       5'd9,  32'h37000080, 32'hffffffff);
    add_vec(vecs, "auipc", {20'h00040, 5'd10, 7'h17},                  32'h100, 32'h40000,    32'h55,       32'h66,       1, 1, 32'h100,      32'h40000,    32'h66,       5'd10, 32'h17000080, 32'hffffffff);
    add_vec(vecs, "jal",   {20'h00000, 5'd1, 7'h6f},                   32'h200, 32'h800,      32'h1,        32'h77,       1, 1, 32'h200,      32'd4,        32'h77,       5'd1,  32'h6f000080, 32'hffffffff);
    add_vec(vecs, "jalr",  {12'd0, 5'd5, 3'b000, 5'd1, 7'h67},         32'h300, 32'h0,        32'h999,      32'h88,       1, 1, 32'h300,      32'd4,        32'h88,       5'd1,  32'h67000080, 32'hffffffff);
    add_vec(vecs, "unk",   32'h0000007f,                               32'h304, 32'h0,        32'h1,        32'h2,        0, 0, 32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0);
    add_vec(vecs, "add2",  add_x3_x1_x2,                               32'h308, 32'h0,        32'd1,        32'd2,        1, 1, 32'd1,        32'd2,        32'd2,        5'd3,  32'h33020000, 32'hffffffff);

    // Reset state
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.in_valid  = 1'b0;
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst ALUc",      bus.ALUc,           32'd0);
    check("rst aluSrcA",   bus.aluSrcA,        32'd0);
    check("rst aluSrcB",   bus.aluSrcB,        32'd0);
    check("rst out_rs2",   bus.out_rs2,        32'd0);
    check("rst out_rd",    32'(bus.out_rd),    32'd0);
    check("rst out_pc",    bus.out_pc,         32'd0);
    reset = 1'b0;

    // Back-to-back decode table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
      bus.out_ready = 1'b1;
      #1;
      check({vecs[i].name, " in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      check({vecs[i].name, " out_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_payload) begin
        check({vecs[i].name, " aluSrcA"}, bus.aluSrcA, vecs[i].exp_a);
        check({vecs[i].name, " aluSrcB"}, bus.aluSrcB, vecs[i].exp_b);
        check({vecs[i].name, " out_rs2"}, bus.out_rs2, vecs[i].exp_rs2);
        check({vecs[i].name, " out_rd"},  32'(bus.out_rd), 32'(vecs[i].exp_rd));
        check({vecs[i].name, " out_pc"},  bus.out_pc, vecs[i].pc);
        check({vecs[i].name, " ALUc"},    bus.ALUc & vecs[i].aluc_mask, vecs[i].exp_aluc);
      end
    end

    // Backpressure: held for 3 cycles, then flush
    drive(add_x3_x1_x2, 32'h500, 32'h0, 32'd5, 32'd7);
    bus.out_ready = 1'b1;
    tick();
    check("bp accept out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    drive(sub_x6_x1_x2, 32'h504, 32'h0, 32'd50, 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp aluSrcA",   bus.aluSrcA, 32'd5);
      check("bp aluSrcB",   bus.aluSrcB, 32'd7);
      check("bp ALUc",      bus.ALUc,    32'h33070000);
      check("bp out_pc",    bus.out_pc,  32'h500);
    end
    flush = 1'b1;
    tick();
    check("flush held out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("flush in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("flush incoming out_valid", 32'(bus.out_valid), 32'd0);
    flush = 1'b0;
    tick();
    check("post-flush out_valid", 32'(bus.out_valid), 32'd1);
    check("post-flush aluSrcA",   bus.aluSrcA, 32'd50);
    check("post-flush ALUc[1]",   32'(bus.ALUc[1]), 32'h20);
    bus.in_valid = 1'b0;
    tick();
    check("drain out_valid", 32'(bus.out_valid), 32'd0);

    // Forwarding: mem over wb, wb alone, x0 never, mem_wen gating
    set_fwd(5'd1, 1'b1, 1'b0, 32'd100, 5'd1, 1'b1, 32'd9);
    drive(sub_x6_x1_x2, 32'h600, 32'h0, 32'd1, 32'd3);
    tick();
    check("fwd mem>wb aluSrcA", bus.aluSrcA, FWD ? 32'd100 : 32'd1);
    check("fwd mem>wb aluSrcB", bus.aluSrcB, 32'd3);
    check("fwd sub ALUc[1]",    32'(bus.ALUc[1]), 32'h20);

    set_fwd(5'd1, 1'b1, 1'b0, 32'd100, 5'd2, 1'b1, 32'd9);
    drive({7'h00, 5'd1, 5'd2, 3'b000, 5'd3, 7'h33}, 32'h604, 32'h0, 32'd11, 32'd22);
    tick();
    check("fwd wb aluSrcA",  bus.aluSrcA, FWD ? 32'd9 : 32'd11);
    check("fwd mem aluSrcB", bus.aluSrcB, FWD ? 32'd100 : 32'd22);
    check("fwd mem out_rs2", bus.out_rs2, FWD ? 32'd100 : 32'd22);
    check("fwd shamt",       32'(bus.ALUc[2]), FWD ? 32'd4 : 32'd22);

    set_fwd(5'd0, 1'b1, 1'b0, 32'd55, 5'd0, 1'b1, 32'd66);
    drive({7'h00, 5'd0, 5'd0, 3'b000, 5'd3, 7'h33}, 32'h608, 32'h0, 32'd0, 32'd0);
    tick();
    check("fwd x0 aluSrcA", bus.aluSrcA, 32'd0);
    check("fwd x0 aluSrcB", bus.aluSrcB, 32'd0);

    set_fwd(5'd1, 1'b0, 1'b0, 32'd100, 5'd1, 1'b1, 32'd9);
    drive({7'h00, 5'd1, 5'd1, 3'b000, 5'd3, 7'h33}, 32'h60c, 32'h0, 32'd1, 32'd1);
    tick();
    check("fwd mem_wen=0 aluSrcA", bus.aluSrcA, FWD ? 32'd9 : 32'd1);

    // Load-use: LW x4 in EX/MEM, ADD x5,x4,x4 waits one cycle
    set_fwd(5'd4, 1'b1, 1'b1, 32'hbad, 5'd0, 1'b0, 32'h0);
    drive({7'h00, 5'd4, 5'd4, 3'b000, 5'd5, 7'h33}, 32'h610, 32'h0, 32'd4, 32'd4);
    #1;
    check("lu in_ready stall", 32'(bus.in_ready), FWD ? 32'd0 : 32'd1);
    tick();
    check("lu bubble out_valid", 32'(bus.out_valid), FWD ? 32'd0 : 32'd1);
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd4, 1'b1, 32'd77);
    #1;
    check("lu in_ready release", 32'(bus.in_ready), 32'd1);
    tick();
    check("lu out_valid", 32'(bus.out_valid), 32'd1);
    check("lu aluSrcA",   bus.aluSrcA, FWD ? 32'd77 : 32'd4);
    check("lu aluSrcB",   bus.aluSrcB, FWD ? 32'd77 : 32'd4);
    check("lu out_rd",    32'(bus.out_rd), 32'd5);

    // Load target matches an rs field LUI does not use: no stall
    set_fwd(5'd8, 1'b1, 1'b1, 32'h123, 5'd0, 1'b0, 32'h0);
    drive(lui_x9, 32'h614, 32'h40000, 32'h0, 32'h0);
    #1;
    check("lu unused rs in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("lu unused rs aluSrcB", bus.aluSrcB, 32'h40000);

    // Reset mid-stream while holding a live instruction
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    drive(add_x3_x1_x2, 32'h700, 32'h0, 32'd5, 32'd7);
    bus.out_ready = 1'b0;
    tick();
    check("mid-rst pre out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid-rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-rst ALUc",      bus.ALUc,    32'd0);
    check("mid-rst aluSrcA",   bus.aluSrcA, 32'd0);
    check("mid-rst aluSrcB",   bus.aluSrcB, 32'd0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("post-rst out_valid", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
